// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Owns the single register-file write port. The in-order write-back stage
// normally wins it. Long-latency results (divider, multi-cycle multiplier)
// take the port when it is free, or wait in a small FIFO. A starve counter
// and a FIFO-full condition force a DRAIN mode. DRAIN freezes write-back
// (stall_o) and empties the FIFO. A 32-bit scoreboard marks destinations
// still waiting on a long-latency result and drives hazard_o for decode.
// The registered rf_* outputs also serve as the WB forwarding source.
//
// Ports
//   clk_sys_i, rst_sys_i           : clock, synchronous active-high reset
//   pipe_wen_i/pipe_rd_i/pipe_data_i : write-back stage write request
//   lu_issue_i/lu_issue_rd_i       : long-latency op dispatched (sets pending)
//   lu_valid_i/lu_rd_i/lu_data_i   : long-latency result, handshake with
//   lu_ready_o                       lu_ready_o
//   rs1_i/rs2_i/rdchk_i            : decode registers to check for hazards
//   hazard_o                       : combinational hazard from the scoreboard
//   stall_o                        : registered, write-back must freeze
//   rf_wen_o/rf_waddr_o/rf_wdata_o : registered register-file write
//   pending_o                      : scoreboard, bit 0 always 0
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int REG_WIDTH    = 64,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_i,
    input  logic                 pipe_wen_i,
    input  logic [4:0]           pipe_rd_i,
    input  logic [REG_WIDTH-1:0] pipe_data_i,
    input  logic                 lu_issue_i,
    input  logic [4:0]           lu_issue_rd_i,
    input  logic                 lu_valid_i,
    input  logic [4:0]           lu_rd_i,
    input  logic [REG_WIDTH-1:0] lu_data_i,
    output logic                 lu_ready_o,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [4:0]           rdchk_i,
    output logic                 hazard_o,
    output logic                 stall_o,
    output logic                 rf_wen_o,
    output logic [4:0]           rf_waddr_o,
    output logic [REG_WIDTH-1:0] rf_wdata_o,
    output logic [31:0]          pending_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {
        PIPE_PRI = 1'b0,
        DRAIN    = 1'b1
    } mode_t;

    // One-hot decode of a register index; index 0 never maps to a bit.
    function automatic logic [31:0] f_onehot(input logic [4:0] idx);
        logic [31:0] v;
        v = 32'd1 << idx;
        v[0] = 1'b0;
        return v;
    endfunction

    mode_t                r_mode;
    mode_t                w_mode_nxt;
    logic [4:0]           r_fifo_rd   [DEPTH];
    logic [REG_WIDTH-1:0] r_fifo_data [DEPTH];
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        w_count_nxt;
    logic [SW-1:0]        r_starve;
    logic [SW-1:0]        w_starve_nxt;
    logic [31:0]          r_pending;
    logic [31:0]          w_pending_nxt;
    logic                 r_rf_wen;
    logic [4:0]           r_rf_waddr;
    logic [REG_WIDTH-1:0] r_rf_wdata;

    logic                 w_lu_ready;
    logic                 w_lu_acc;
    logic                 w_fifo_ne;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_bypass;
    logic                 w_sel_valid;
    logic                 w_sel_lu;
    logic [4:0]           w_sel_rd;
    logic [REG_WIDTH-1:0] w_sel_data;
    logic                 w_write;

    assign w_lu_ready = (r_count < CW'(DEPTH));
    assign w_lu_acc   = lu_valid_i & w_lu_ready;
    assign w_fifo_ne  = (r_count != {CW{1'b0}});

    // Port arbitration: choose the source for this cycle's write.
    always_comb begin
        w_pop       = 1'b0;
        w_bypass    = 1'b0;
        w_sel_valid = 1'b0;
        w_sel_lu    = 1'b0;
        w_sel_rd    = 5'd0;
        w_sel_data  = {REG_WIDTH{1'b0}};
        case (r_mode)
            PIPE_PRI: begin
                if (pipe_wen_i && (pipe_rd_i != 5'd0)) begin
                    w_sel_valid = 1'b1;
                    w_sel_rd    = pipe_rd_i;
                    w_sel_data  = pipe_data_i;
                end else if (w_fifo_ne) begin
                    w_pop       = 1'b1;
                    w_sel_valid = 1'b1;
                    w_sel_lu    = 1'b1;
                    w_sel_rd    = r_fifo_rd[r_rptr];
                    w_sel_data  = r_fifo_data[r_rptr];
                end else if (w_lu_acc) begin
                    w_bypass    = 1'b1;
                    w_sel_valid = 1'b1;
                    w_sel_lu    = 1'b1;
                    w_sel_rd    = lu_rd_i;
                    w_sel_data  = lu_data_i;
                end else begin
                    w_sel_valid = 1'b0;
                end
            end
            DRAIN: begin
                // Write-back is frozen; the FIFO head goes out every cycle.
                if (w_fifo_ne) begin
                    w_pop       = 1'b1;
                    w_sel_valid = 1'b1;
                    w_sel_lu    = 1'b1;
                    w_sel_rd    = r_fifo_rd[r_rptr];
                    w_sel_data  = r_fifo_data[r_rptr];
                end else if (w_lu_acc) begin
                    w_bypass    = 1'b1;
                    w_sel_valid = 1'b1;
                    w_sel_lu    = 1'b1;
                    w_sel_rd    = lu_rd_i;
                    w_sel_data  = lu_data_i;
                end else begin
                    w_sel_valid = 1'b0;
                end
            end
            default: begin
                w_sel_valid = 1'b0;
            end
        endcase
    end

    assign w_push  = w_lu_acc & ~w_bypass;
    // A destination of x0 leaves the port free and is never written.
    assign w_write = w_sel_valid & (w_sel_rd != 5'd0);

    // Next FIFO occupancy, starve count, mode and scoreboard.
    always_comb begin
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        if (w_pop) begin
            w_starve_nxt = {SW{1'b0}};
        end else if (w_fifo_ne && (r_starve != SW'(STARVE_LIMIT))) begin
            w_starve_nxt = r_starve + SW'(1);
        end else begin
            w_starve_nxt = r_starve;
        end
        w_mode_nxt = r_mode;
        case (r_mode)
            PIPE_PRI: begin
                if ((w_starve_nxt == SW'(STARVE_LIMIT)) || (w_count_nxt == CW'(DEPTH))) begin
                    w_mode_nxt = DRAIN;
                end else begin
                    w_mode_nxt = PIPE_PRI;
                end
            end
            DRAIN: begin
                if (w_count_nxt == {CW{1'b0}}) begin
                    w_mode_nxt = PIPE_PRI;
                end else begin
                    w_mode_nxt = DRAIN;
                end
            end
            default: w_mode_nxt = PIPE_PRI;
        endcase
        // Clear first, then set, so a same-cycle issue of the same rd wins.
        w_pending_nxt = r_pending;
        if (w_write && w_sel_lu) begin
            w_pending_nxt = w_pending_nxt & ~f_onehot(w_sel_rd);
        end else begin
            w_pending_nxt = w_pending_nxt;
        end
        if (lu_issue_i) begin
            w_pending_nxt = w_pending_nxt | f_onehot(lu_issue_rd_i);
        end else begin
            w_pending_nxt = w_pending_nxt;
        end
    end

    // Control state, scoreboard and registered write port.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_mode     <= PIPE_PRI;
            r_wptr     <= {PW{1'b0}};
            r_rptr     <= {PW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_starve   <= {SW{1'b0}};
            r_pending  <= 32'd0;
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= {REG_WIDTH{1'b0}};
        end else begin
            r_mode    <= w_mode_nxt;
            r_count   <= w_count_nxt;
            r_starve  <= w_starve_nxt;
            r_pending <= w_pending_nxt;
            r_rf_wen  <= w_write;
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_write) begin
                r_rf_waddr <= w_sel_rd;
                r_rf_wdata <= w_sel_data;
            end
        end
    end

    // FIFO storage; contents are only meaningful below r_count, so no reset.
    always_ff @(posedge clk_sys_i) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= lu_rd_i;
            r_fifo_data[r_wptr] <= lu_data_i;
        end
    end

    assign lu_ready_o = w_lu_ready;
    assign stall_o    = (r_mode == DRAIN);
    assign rf_wen_o   = r_rf_wen;
    assign rf_waddr_o = r_rf_waddr;
    assign rf_wdata_o = r_rf_wdata;
    assign pending_o  = r_pending;
    assign hazard_o   = r_pending[rs1_i] | r_pending[rs2_i] | r_pending[rdchk_i];

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wen;
    logic [4:0]  pipe_rd;
    logic [63:0] pipe_data;
    logic        lu_issue;
    logic [4:0]  lu_issue_rd;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [63:0] lu_data;
    logic        lu_ready;
    logic [4:0]  rs1, rs2, rdchk;
    logic        hazard, stall, rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(.REG_WIDTH(64), .DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk_sys_i(clk), .rst_sys_i(rst),
        .pipe_wen_i(pipe_wen), .pipe_rd_i(pipe_rd), .pipe_data_i(pipe_data),
        .lu_issue_i(lu_issue), .lu_issue_rd_i(lu_issue_rd),
        .lu_valid_i(lu_valid), .lu_rd_i(lu_rd), .lu_data_i(lu_data),
        .lu_ready_o(lu_ready),
        .rs1_i(rs1), .rs2_i(rs2), .rdchk_i(rdchk),
        .hazard_o(hazard), .stall_o(stall),
        .rf_wen_o(rf_wen), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .pending_o(pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_wen = 1'b0; pipe_rd = 5'd0; pipe_data = 64'd0;
        lu_issue = 1'b0; lu_issue_rd = 5'd0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 64'd0;
        rs1 = 5'd0; rs2 = 5'd0; rdchk = 5'd0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %0b exp 0", rf_wen); end
        n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr got %0d exp 0", rf_waddr); end
        n_checks++; if (rf_wdata !== 64'd0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", rf_wdata); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b exp 0", stall); end
        n_checks++; if (pending !== 32'd0) begin n_fail++; $display("FAIL reset_pending got %h exp 0", pending); end
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %0b exp 0", hazard); end
        n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b exp 1", lu_ready); end
        rst = 1'b0;
    endtask

    task automatic test_pipe_write();
        idle();
        pipe_wen = 1'b1; pipe_rd = 5'd5; pipe_data = 64'h1234;
        tick();
        pipe_rd = 5'd0; pipe_data = 64'h5555;
        n_checks++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL pipe_wen got %0b exp 1", rf_wen); end
        n_checks++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL pipe_waddr got %0d exp 5", rf_waddr); end
        n_checks++; if (rf_wdata !== 64'h1234) begin n_fail++; $display("FAIL pipe_wdata got %h exp 1234", rf_wdata); end
        tick();
        pipe_wen = 1'b0;
        n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL pipe_rd0_wen got %0b exp 0", rf_wen); end
        n_checks++; if (rf_wdata !== 64'h1234) begin n_fail++; $display("FAIL pipe_rd0_hold got %h exp 1234", rf_wdata); end
        n_checks++; if (pending !== 32'd0) begin n_fail++; $display("FAIL pipe_pending got %h exp 0", pending); end
        tick();
    endtask

    task automatic test_bypass_scoreboard();
        idle();
        lu_issue = 1'b1; lu_issue_rd = 5'd7;
        tick();
        lu_issue = 1'b0;
        rs1 = 5'd7;
        #1;
        n_checks++; if (pending[7] !== 1'b1) begin n_fail++; $display("FAIL sb_set got %0b exp 1", pending[7]); end
        n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_rs1 got %0b exp 1", hazard); end
        rs1 = 5'd0; rdchk = 5'd7;
        #1;
        n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_rd got %0b exp 1", hazard); end
        rs1 = 5'd7; rdchk = 5'd0;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 64'hAB;
        tick();
        lu_valid = 1'b0;
        #1;
        n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 64'hAB)
            begin n_fail++; $display("FAIL bypass_write got %0b/%0d/%h exp 1/7/ab", rf_wen, rf_waddr, rf_wdata); end
        n_checks++; if (pending[7] !== 1'b0) begin n_fail++; $display("FAIL sb_clear got %0b exp 0", pending[7]); end
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL sb_hazard_clear got %0b exp 0", hazard); end
        idle();
        tick();
    endtask

    task automatic test_starvation();
        idle();
        pipe_wen = 1'b1; pipe_rd = 5'd1; pipe_data = 64'h1;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 64'h99;
        tick();
        lu_valid = 1'b0;
        n_checks++; if (rf_waddr !== 5'd1) begin n_fail++; $display("FAIL starve_first got %0d exp 1", rf_waddr); end
        for (int i = 0; i < 8; i++) begin
            pipe_rd = 5'(10 + i); pipe_data = 64'(100 + i);
            tick();
            n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(10 + i))
                begin n_fail++; $display("FAIL starve_pipe_win[%0d] got %0b/%0d exp 1/%0d", i, rf_wen, rf_waddr, 10 + i); end
            n_checks++; if (stall !== (i == 7))
                begin n_fail++; $display("FAIL starve_stall[%0d] got %0b exp %0b", i, stall, (i == 7)); end
        end
        pipe_rd = 5'd20; pipe_data = 64'h20;
        tick();
        n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'h99)
            begin n_fail++; $display("FAIL starve_drain got %0b/%0d/%h exp 1/9/99", rf_wen, rf_waddr, rf_wdata); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL starve_exit got %0b exp 0", stall); end
        tick();
        n_checks++; if (rf_waddr !== 5'd20) begin n_fail++; $display("FAIL starve_replay got %0d exp 20", rf_waddr); end
        idle();
        tick();
    endtask

    task automatic test_full();
        idle();
        pipe_wen = 1'b1; pipe_rd = 5'd1; pipe_data = 64'h1;
        lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 64'h44;
        tick();
        lu_rd = 5'd6; lu_data = 64'h66;
        tick();
        lu_rd = 5'd8; lu_data = 64'h88;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got %0b exp 1", stall); end
        n_checks++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b exp 0", lu_ready); end
        tick();
        n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 64'h44)
            begin n_fail++; $display("FAIL full_first got %0b/%0d/%h exp 1/4/44", rf_wen, rf_waddr, rf_wdata); end
        n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_again got %0b exp 1", lu_ready); end
        tick();
        lu_valid = 1'b0;
        n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 64'h66)
            begin n_fail++; $display("FAIL full_second got %0b/%0d/%h exp 1/6/66", rf_wen, rf_waddr, rf_wdata); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_still_drain got %0b exp 1", stall); end
        tick();
        n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 64'h88)
            begin n_fail++; $display("FAIL full_third got %0b/%0d/%h exp 1/8/88", rf_wen, rf_waddr, rf_wdata); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL full_exit got %0b exp 0", stall); end
        idle();
        tick();
    endtask

    task automatic test_issue_retire();
        idle();
        lu_issue = 1'b1; lu_issue_rd = 5'd3;
        tick();
        n_checks++; if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL ir_set got %0b exp 1", pending[3]); end
        lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 64'h33;
        tick();
        lu_issue = 1'b0; lu_data = 64'h34;
        n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3) begin n_fail++; $display("FAIL ir_write got %0b/%0d exp 1/3", rf_wen, rf_waddr); end
        n_checks++; if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL ir_set_wins got %0b exp 1", pending[3]); end
        tick();
        lu_valid = 1'b0;
        n_checks++; if (pending[3] !== 1'b0 || rf_wdata !== 64'h34)
            begin n_fail++; $display("FAIL ir_clear got %0b/%h exp 0/34", pending[3], rf_wdata); end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_drain();
        idle();
        lu_issue = 1'b1; lu_issue_rd = 5'd12;
        pipe_wen = 1'b1; pipe_rd = 5'd2; pipe_data = 64'h2;
        tick();
        lu_issue = 1'b0;
        lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 64'hC;
        tick();
        lu_rd = 5'd13; lu_data = 64'hD;
        tick();
        lu_valid = 1'b0;
        n_checks++; if (stall !== 1'b1 || pending[12] !== 1'b1)
            begin n_fail++; $display("FAIL rd_precond got %0b/%0b exp 1/1", stall, pending[12]); end
        rst = 1'b1;
        tick();
        n_checks++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0)
            begin n_fail++; $display("FAIL rd_rf got %0b/%0d/%h exp 0/0/0", rf_wen, rf_waddr, rf_wdata); end
        n_checks++; if (stall !== 1'b0 || pending !== 32'd0 || lu_ready !== 1'b1)
            begin n_fail++; $display("FAIL rd_ctrl got %0b/%h/%0b exp 0/0/1", stall, pending, lu_ready); end
        tick();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (rf_wen !== 1'b0 || stall !== 1'b0)
                begin n_fail++; $display("FAIL rd_quiet[%0d] got %0b/%0b exp 0/0", i, rf_wen, stall); end
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_pipe_write();
        test_bypass_scoreboard();
        test_starvation();
        test_full();
        test_issue_retire();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
